// File: rtl/regfile.sv
// Simple-MIPS general-purpose register file: one write port from WB, two combinational read ports to ID.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to a matching read port (WB->ID bypass).
module regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2
);

    localparam int NREGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];
    logic              byp1;
    logic              byp2;

    // Reset wins over a write in the same cycle; entry 0 is forced to zero so it never holds data.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, otherwise a latch is inferred.
        regs_d = regs_q;
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) regs_d[i] = '0;
        end else if (we && (waddr != '0)) begin
            regs_d[waddr] = wdata;
        end
        regs_d[0] = '0;
    end

    // NOTE: the whole array is cleared on reset because software may read any register before writing it;
    // state is updated with non-blocking assignments only.
    always_ff @(posedge clk) begin
        regs_q <= regs_d;
    end

`ifdef REGFILE_BYPASS_EN
    assign byp1 = rst && re1 && we && (waddr == raddr1) && (waddr != '0);
    assign byp2 = rst && re2 && we && (waddr == raddr2) && (waddr != '0);
`else
    assign byp1 = 1'b0;
    assign byp2 = 1'b0;
`endif

    function automatic logic [DATA_W-1:0] read_port(
        input logic              rst_v,
        input logic              re_v,
        input logic [ADDR_W-1:0] raddr_v,
        input logic              byp_v,
        input logic [DATA_W-1:0] wdata_v,
        input logic [DATA_W-1:0] stored_v
    );
        if (!rst_v || !re_v || (raddr_v == '0)) return '0;
        if (byp_v) return wdata_v;
        return stored_v;
    endfunction

    always_comb begin
        rdata1 = read_port(rst, re1, raddr1, byp1, wdata, regs_q[raddr1]);
        rdata2 = read_port(rst, re2, raddr2, byp2, wdata, regs_q[raddr2]);
    end

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: expected read data is queued as stimulus is driven and compared mid-cycle.
// Expectations for same-cycle write/read follow REGFILE_BYPASS_EN, the same macro the design sees.
module tb_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        re1;
    logic [4:0]  raddr1;
    logic [31:0] rdata1;
    logic        re2;
    logic [4:0]  raddr2;
    logic [31:0] rdata2;

    typedef struct {
        string       name;
        logic [31:0] d1;
        logic [31:0] d2;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        e;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] model [32];

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    regfile dut (
        .clk   (clk),
        .rst   (rst),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .re1   (re1),
        .raddr1(raddr1),
        .rdata1(rdata1),
        .re2   (re2),
        .raddr2(raddr2),
        .rdata2(rdata2)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic rst_v, input logic we_v, input logic [4:0] wa,
                         input logic [31:0] wd, input logic r1e, input logic [4:0] ra1,
                         input logic r2e, input logic [4:0] ra2);
        rst = rst_v; we = we_v; waddr = wa; wdata = wd;
        re1 = r1e; raddr1 = ra1; re2 = r2e; raddr2 = ra2;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        next_cycle();
        drive(1, 1, 5'd5, 32'hDEADBEEF, 1, 5'd5, 1, 5'd5);
        sb_q.push_back('{"reset_pre_write", BYP ? 32'hDEADBEEF : 32'h0, BYP ? 32'hDEADBEEF : 32'h0});
        @(negedge clk); e = sb_q.pop_front(); checks++;
        if (rdata1 !== e.d1 || rdata2 !== e.d2) begin errors++;
            $display("FAIL %s: got %h/%h want %h/%h", e.name, rdata1, rdata2, e.d1, e.d2); end
        next_cycle();
        drive(0, 0, 5'd0, 32'h0, 1, 5'd5, 1, 5'd5);
        sb_q.push_back('{"reset_held_reads_zero", 32'h0, 32'h0});
        @(negedge clk); e = sb_q.pop_front(); checks++;
        if (rdata1 !== e.d1 || rdata2 !== e.d2) begin errors++;
            $display("FAIL %s: got %h/%h want %h/%h", e.name, rdata1, rdata2, e.d1, e.d2); end
        next_cycle();
        drive(1, 0, 5'd0, 32'h0, 1, 5'd5, 1, 5'd5);
        model[5] = 32'h0;
        sb_q.push_back('{"reset_cleared_r5", 32'h0, 32'h0});
        @(negedge clk); e = sb_q.pop_front(); checks++;
        if (rdata1 !== e.d1 || rdata2 !== e.d2) begin errors++;
            $display("FAIL %s: got %h/%h want %h/%h", e.name, rdata1, rdata2, e.d1, e.d2); end
    endtask

    task automatic test_basic();
        next_cycle();
        drive(1, 1, 5'd7, 32'h12345678, 1, 5'd7, 1, 5'd8);
        sb_q.push_back('{"basic_write_cycle", BYP ? 32'h12345678 : 32'h0, 32'h0});
        @(negedge clk); e = sb_q.pop_front(); checks++;
        if (rdata1 !== e.d1 || rdata2 !== e.d2) begin errors++;
            $display("FAIL %s: got %h/%h want %h/%h", e.name, rdata1, rdata2, e.d1, e.d2); end
        next_cycle();
        drive(1, 0, 5'd0, 32'h0, 1, 5'd7, 1, 5'd8);
        sb_q.push_back('{"basic_readback", 32'h12345678, 32'h0});
        @(negedge clk); e = sb_q.pop_front(); checks++;
        if (rdata1 !== e.d1 || rdata2 !== e.d2) begin errors++;
            $display("FAIL %s: got %h/%h want %h/%h", e.name, rdata1, rdata2, e.d1, e.d2); end
    endtask

    task automatic test_r0();
        next_cycle();
        drive(1, 1, 5'd0, 32'hFFFFFFFF, 1, 5'd0, 1, 5'd0);
        sb_q.push_back('{"r0_write_cycle", 32'h0, 32'h0});
        @(negedge clk); e = sb_q.pop_front(); checks++;
        if (rdata1 !== e.d1 || rdata2 !== e.d2) begin errors++;
            $display("FAIL %s: got %h/%h want %h/%h", e.name, rdata1, rdata2, e.d1, e.d2); end
        for (int k = 0; k < 2; k++) begin
            next_cycle();
            drive(1, 0, 5'd0, 32'h0, 1, 5'd0, 1, 5'd0);
            sb_q.push_back('{"r0_after_write", 32'h0, 32'h0});
            @(negedge clk); e = sb_q.pop_front(); checks++;
            if (rdata1 !== e.d1 || rdata2 !== e.d2) begin errors++;
                $display("FAIL %s: got %h/%h want %h/%h", e.name, rdata1, rdata2, e.d1, e.d2); end
        end
    endtask

    task automatic test_read_enable();
        next_cycle();
        drive(1, 1, 5'd3, 32'hA5A5A5A5, 0, 5'd0, 0, 5'd0);
        next_cycle();
        drive(1, 0, 5'd0, 32'h0, 0, 5'd3, 1, 5'd3);
        sb_q.push_back('{"re1_gated", 32'h0, 32'hA5A5A5A5});
        @(negedge clk); e = sb_q.pop_front(); checks++;
        if (rdata1 !== e.d1 || rdata2 !== e.d2) begin errors++;
            $display("FAIL %s: got %h/%h want %h/%h", e.name, rdata1, rdata2, e.d1, e.d2); end
        next_cycle();
        drive(1, 0, 5'd0, 32'h0, 1, 5'd3, 0, 5'd3);
        sb_q.push_back('{"re2_gated", 32'hA5A5A5A5, 32'h0});
        @(negedge clk); e = sb_q.pop_front(); checks++;
        if (rdata1 !== e.d1 || rdata2 !== e.d2) begin errors++;
            $display("FAIL %s: got %h/%h want %h/%h", e.name, rdata1, rdata2, e.d1, e.d2); end
    endtask

    task automatic test_hazard();
        next_cycle();
        drive(1, 1, 5'd9, 32'h1, 0, 5'd0, 0, 5'd0);
        next_cycle();
        drive(1, 1, 5'd9, 32'h2, 1, 5'd9, 1, 5'd9);
        sb_q.push_back('{"hazard_same_cycle", BYP ? 32'h2 : 32'h1, BYP ? 32'h2 : 32'h1});
        @(negedge clk); e = sb_q.pop_front(); checks++;
        if (rdata1 !== e.d1 || rdata2 !== e.d2) begin errors++;
            $display("FAIL %s: got %h/%h want %h/%h", e.name, rdata1, rdata2, e.d1, e.d2); end
        next_cycle();
        drive(1, 0, 5'd0, 32'h0, 1, 5'd9, 1, 5'd9);
        sb_q.push_back('{"hazard_next_cycle", 32'h2, 32'h2});
        @(negedge clk); e = sb_q.pop_front(); checks++;
        if (rdata1 !== e.d1 || rdata2 !== e.d2) begin errors++;
            $display("FAIL %s: got %h/%h want %h/%h", e.name, rdata1, rdata2, e.d1, e.d2); end
    endtask

    task automatic test_reset_during_write();
        next_cycle();
        drive(0, 1, 5'd4, 32'h55, 1, 5'd4, 1, 5'd4);
        sb_q.push_back('{"rstwr_during_reset", 32'h0, 32'h0});
        @(negedge clk); e = sb_q.pop_front(); checks++;
        if (rdata1 !== e.d1 || rdata2 !== e.d2) begin errors++;
            $display("FAIL %s: got %h/%h want %h/%h", e.name, rdata1, rdata2, e.d1, e.d2); end
        next_cycle();
        drive(1, 0, 5'd0, 32'h0, 1, 5'd4, 1, 5'd9);
        sb_q.push_back('{"rstwr_write_lost", 32'h0, 32'h0});
        @(negedge clk); e = sb_q.pop_front(); checks++;
        if (rdata1 !== e.d1 || rdata2 !== e.d2) begin errors++;
            $display("FAIL %s: got %h/%h want %h/%h", e.name, rdata1, rdata2, e.d1, e.d2); end
        next_cycle();
        drive(1, 1, 5'd4, 32'h66, 1, 5'd4, 1, 5'd4);
        next_cycle();
        drive(1, 0, 5'd0, 32'h0, 1, 5'd4, 1, 5'd4);
        sb_q.push_back('{"rstwr_rewrite", 32'h66, 32'h66});
        @(negedge clk); e = sb_q.pop_front(); checks++;
        if (rdata1 !== e.d1 || rdata2 !== e.d2) begin errors++;
            $display("FAIL %s: got %h/%h want %h/%h", e.name, rdata1, rdata2, e.d1, e.d2); end
    endtask

    task automatic test_back_to_back();
        for (int i = 1; i < 32; i++) begin
            model[i] = $urandom;
            next_cycle();
            drive(1, 1, 5'(i), model[i], 1, 5'd0, 0, 5'd0);
        end
        model[0] = 32'h0;
        for (int i = 0; i < 32; i++) begin
            next_cycle();
            drive(1, 0, 5'd0, 32'h0, 1, 5'(i), 1, 5'(31 - i));
            sb_q.push_back('{$sformatf("b2b_r%0d_r%0d", i, 31 - i), model[i], model[31 - i]});
            @(negedge clk); e = sb_q.pop_front(); checks++;
            if (rdata1 !== e.d1 || rdata2 !== e.d2) begin errors++;
                $display("FAIL %s: got %h/%h want %h/%h", e.name, rdata1, rdata2, e.d1, e.d2); end
        end
    endtask

    initial begin
        drive(0, 0, 5'd0, 32'h0, 0, 5'd0, 0, 5'd0);
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        test_reset();
        test_basic();
        test_r0();
        test_read_enable();
        test_hazard();
        test_reset_during_write();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
